// File: rtl/donut_frame_sequencer.sv
// Purpose: playback controller for the donut animation ROM (address/enable generation, frame pacing, pixel return).
// Latency: pix_valid_o/pix_o one cycle after each pix_req_i (ROM read latency is one cycle).
// Backpressure: none; one request per cycle accepted at full rate, requests on a vsync edge are dropped.
module donut_frame_sequencer #(
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 220,
    parameter int NUM_FRAMES = 30,
    parameter int FRAME_DIV  = 2,
    parameter int ADDR_W     = 32,
    parameter int PIX_W      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          mode_i,
    input  logic                          vsync_i,
    input  logic                          pix_req_i,
    output logic                          rom_cen_o,
    output logic [ADDR_W-1:0]             rom_addr_o,
    input  logic [PIX_W-1:0]              rom_data_i,
    output logic [PIX_W-1:0]              pix_o,
    output logic                          pix_valid_o,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx_o,
    output logic                          ovf_o,
    output logic                          err_o
);
    localparam int FRAME_SIZE = FRAME_W * FRAME_H;
    localparam int IDX_W      = $clog2(NUM_FRAMES);
    localparam int CNT_W      = $clog2(FRAME_SIZE + 1);
    localparam int PACE_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [ADDR_W-1:0] FS_A      = ADDR_W'(FRAME_SIZE);
    localparam logic [CNT_W-1:0]  FS_C      = CNT_W'(FRAME_SIZE);
    localparam logic [IDX_W-1:0]  LAST      = IDX_W'(NUM_FRAMES - 1);
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(FRAME_DIV - 1);

    typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

    dir_t              dir_q, dir_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PACE_W-1:0] pace_q;
    logic              vsync_q;
    logic              valid_q, hit_q, ovf_q, err_q;

    logic vs_rise, pace_wrap, step, in_range, accept, overflow;

    assign vs_rise   = vsync_i & ~vsync_q;
    assign pace_wrap = (pace_q == PACE_LAST);
    assign step      = vs_rise & en_i & pace_wrap;
    assign in_range  = (cnt_q < FS_C);
    assign accept    = pix_req_i & ~vs_rise & in_range;
    assign overflow  = pix_req_i & ~vs_rise & ~in_range;

    assign rom_cen_o   = accept;
    assign rom_addr_o  = addr_q;
    assign pix_valid_o = valid_q;
    assign pix_o       = hit_q ? rom_data_i : '0;
    assign frame_idx_o = idx_q;
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;

    // Direction state register; only moves when the frame actually steps.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) dir_q <= FWD;
        else if (step) dir_q <= dir_d;
    end

    // Next direction, frame index and incrementally tracked frame base for one step.
    always_comb begin
        dir_d  = dir_q;
        idx_d  = idx_q;
        base_d = base_q;
        if (!mode_i || dir_q == FWD) begin
            // Loop mode always runs forward, even if ping-pong left us in REV.
            dir_d = FWD;
            if (idx_q == LAST) begin
                if (mode_i) begin
                    dir_d  = REV;
                    idx_d  = idx_q - IDX_W'(1);
                    base_d = base_q - FS_A;
                end else begin
                    idx_d  = '0;
                    base_d = '0;
                end
            end else begin
                idx_d  = idx_q + IDX_W'(1);
                base_d = base_q + FS_A;
            end
        end else begin
            if (idx_q == '0) begin
                dir_d  = FWD;
                idx_d  = idx_q + IDX_W'(1);
                base_d = base_q + FS_A;
            end else begin
                idx_d  = idx_q - IDX_W'(1);
                base_d = base_q - FS_A;
            end
        end
    end

    // Vsync edge history, pace divider and current frame index/base.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vsync_q <= 1'b0;
            pace_q  <= '0;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            vsync_q <= vsync_i;
            if (vs_rise && en_i) pace_q <= pace_wrap ? '0 : pace_q + PACE_W'(1);
            if (step) begin
                idx_q  <= idx_d;
                base_q <= base_d;
            end
        end
    end

    // ROM address and pixel count: rewind to the (new) frame base on vsync, advance per accepted read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (vs_rise) begin
            addr_q <= step ? base_d : base_q;
            cnt_q  <= '0;
        end else if (accept) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Response strobe aligned with ROM data, plus sticky overflow/error flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= accept | overflow;
            hit_q   <= accept;
            if (overflow) ovf_q <= 1'b1;
            if (pix_req_i && vs_rise) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_donut_frame_sequencer.sv
// Purpose: self-checking bench for donut_frame_sequencer with a pixel scoreboard and a FRAME_DIV=2 companion.
// Latency: expects each pixel response one cycle after its request.
// Backpressure: none; requests are driven back-to-back where the scenario calls for it.
module tb_donut_frame_sequencer;
    localparam int FW = 4, FH = 2, NF = 3, FS = FW * FH, AW = 32, PW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, mode, vsync, pix_req;
    logic          cen, pix_valid, ovf, err;
    logic [AW-1:0] addr;
    logic [PW-1:0] rom_q = '0;
    logic [PW-1:0] pix;
    logic [1:0]    fidx;

    logic          d2_cen, d2_pix_valid, d2_ovf, d2_err;
    logic [AW-1:0] d2_addr;
    logic [PW-1:0] d2_pix;
    logic [1:0]    d2_fidx;

    int n_chk = 0;
    int n_err = 0;
    logic [PW-1:0] sb_q[$];

    donut_frame_sequencer #(.FRAME_W(FW), .FRAME_H(FH), .NUM_FRAMES(NF), .FRAME_DIV(1),
                            .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .vsync_i(vsync),
        .pix_req_i(pix_req), .rom_cen_o(cen), .rom_addr_o(addr), .rom_data_i(rom_q),
        .pix_o(pix), .pix_valid_o(pix_valid), .frame_idx_o(fidx), .ovf_o(ovf), .err_o(err)
    );

    donut_frame_sequencer #(.FRAME_W(FW), .FRAME_H(FH), .NUM_FRAMES(NF), .FRAME_DIV(2),
                            .ADDR_W(AW), .PIX_W(PW)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .vsync_i(vsync),
        .pix_req_i(pix_req), .rom_cen_o(d2_cen), .rom_addr_o(d2_addr), .rom_data_i(rom_q),
        .pix_o(d2_pix), .pix_valid_o(d2_pix_valid), .frame_idx_o(d2_fidx), .ovf_o(d2_ovf),
        .err_o(d2_err)
    );

    // ROM contents are addr[3:0]; one-cycle synchronous read.
    always @(posedge clk) if (cen) rom_q <= addr[3:0];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every pixel strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            if (sb_q.size() == 0) chk("unexp_valid", {31'd0, pix_valid}, 32'd0);
            else chk("pix", {28'd0, pix}, {28'd0, sb_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit exp_cen, input logic [31:0] exp_addr);
        pix_req = 1'b1;
        @(negedge clk);
        chk("cen", {31'd0, cen}, {31'd0, exp_cen});
        if (exp_cen) chk("addr", addr, exp_addr);
        sb_q.push_back(exp_cen ? exp_addr[3:0] : 4'd0);
        tick();
        pix_req = 1'b0;
    endtask

    task automatic pulse(input int exp_idx, input int exp2_idx, input bit chk2);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("frame_idx", {30'd0, fidx}, 32'(exp_idx));
        chk("base_addr", addr, 32'(exp_idx * FS));
        if (chk2) chk("div2_idx", {30'd0, d2_fidx}, 32'(exp2_idx));
        tick();
    endtask

    int seq[5] = '{1, 2, 1, 0, 1};

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; vsync = 1'b0; pix_req = 1'b0;
        repeat (3) tick();
        chk("rst_cen", {31'd0, cen}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_pix", {28'd0, pix}, 32'd0);
        chk("rst_idx", {30'd0, fidx}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full frame of back-to-back reads, then one request past the end.
        for (int k = 0; k < FS; k++) req(1'b1, 32'(k));
        req(1'b0, 32'd0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("err_clear", {31'd0, err}, 32'd0);

        // Loop mode; companion instance steps on every second edge.
        pulse(1, 0, 1'b1); req(1'b1, 32'd8);
        pulse(2, 1, 1'b1); req(1'b1, 32'd16);
        pulse(0, 1, 1'b1); req(1'b1, 32'd0);
        pulse(1, 2, 1'b1); req(1'b1, 32'd8);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Ping-pong from frame 0, freeze, then mode switch while reversing.
        pulse(2, 0, 1'b0);
        pulse(0, 0, 1'b0);
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse(seq[i], 0, 1'b0);
            req(1'b1, 32'(seq[i] * FS));
        end
        en = 1'b0;
        pulse(1, 0, 1'b0); req(1'b1, 32'd8);
        en = 1'b1;
        pulse(2, 0, 1'b0);
        pulse(1, 0, 1'b0);
        mode = 1'b0;
        pulse(2, 0, 1'b0);
        pulse(0, 0, 1'b0);

        // Request colliding with a vsync edge is dropped and flagged.
        vsync = 1'b1; pix_req = 1'b1;
        @(negedge clk);
        chk("drop_cen", {31'd0, cen}, 32'd0);
        tick();
        chk("err_set", {31'd0, err}, 32'd1);
        chk("drop_valid", {31'd0, pix_valid}, 32'd0);
        chk("drop_idx", {30'd0, fidx}, 32'd1);
        vsync = 1'b0; pix_req = 1'b0;
        tick();
        req(1'b1, 32'd8);
        pulse(2, 0, 1'b0);
        chk("ovf_sticky2", {31'd0, ovf}, 32'd1);

        // Reset mid-frame at frame 2, address 19, with a request in flight.
        req(1'b1, 32'd16); req(1'b1, 32'd17); req(1'b1, 32'd18);
        chk("pre_rst_addr", addr, 32'd19);
        pix_req = 1'b1; rst_n = 1'b0;
        tick();
        pix_req = 1'b0;
        #1;
        chk("mrst_cen", {31'd0, cen}, 32'd0);
        chk("mrst_addr", addr, 32'd0);
        chk("mrst_valid", {31'd0, pix_valid}, 32'd0);
        chk("mrst_pix", {28'd0, pix}, 32'd0);
        chk("mrst_idx", {30'd0, fidx}, 32'd0);
        chk("mrst_ovf", {31'd0, ovf}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        req(1'b1, 32'd0);

        repeat (3) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
